// File: rtl/commit_pointer_ctrl.sv
// In-order commit scheduler for the 64-entry commit ring: owns the tail (allocation), head (commit) and count registers.
// Latency: commit strobes and tags are combinational from the registered head (0 cycles); pointers update on the next edge.
// Backpressure: none internally; upstream stalls allocation with iLOCK while oFULL, restart squashes commit in the same cycle.
//
// Ports
//   iCLOCK / iRESET_SYNC         : clock, synchronous active-high reset (dominates everything)
//   iLOCK, iREGIST_0/1_VALID     : allocate 0..2 entries at oREGIST_POINTER when not locked
//   iRESTART_VALID               : flush; suppresses commit this cycle, clears head/tail/count at the edge
//   iENTRY_VALID/EX_END/EX_BRANCH: per-entry status from the ring
//   oREGIST_POINTER, oFULL, oEMPTY
//   oCOMMIT_VALID                : per-entry commit strobes (bit head, bit head+1)
//   oCOMMIT_0/1_VALID, _TAG      : retired entry ids, tags read 0 when the slot does not retire
//
// Build option: COMMIT_CTRL_DUAL_COMMIT_EN enables the second retire slot; without it at most one
// entry retires per cycle and slot-1 outputs stay at 0.

module commit_pointer_ctrl #(
    parameter int PTR_W   = 6,
    parameter int ENTRY_N = 64
) (
    input  logic               iCLOCK,
    input  logic               iRESET_SYNC,
    input  logic               iLOCK,
    input  logic               iRESTART_VALID,
    input  logic               iREGIST_0_VALID,
    input  logic               iREGIST_1_VALID,
    input  logic [ENTRY_N-1:0] iENTRY_VALID,
    input  logic [ENTRY_N-1:0] iENTRY_EX_END,
    input  logic [ENTRY_N-1:0] iENTRY_EX_BRANCH,
    output logic [PTR_W-1:0]   oREGIST_POINTER,
    output logic               oFULL,
    output logic               oEMPTY,
    output logic [ENTRY_N-1:0] oCOMMIT_VALID,
    output logic               oCOMMIT_0_VALID,
    output logic [PTR_W-1:0]   oCOMMIT_0_TAG,
    output logic               oCOMMIT_1_VALID,
    output logic [PTR_W-1:0]   oCOMMIT_1_TAG
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PTR_W-1:0]   head_p1;
    logic [1:0]         n_reg;
    logic [1:0]         n_com;
    logic               c0;
    logic               c1;
    logic [ENTRY_N-1:0] commit_vec;

`ifndef COMMIT_CTRL_DUAL_COMMIT_EN
    // Branch status only matters for pairing a second retire.
    logic unused_branch;
    assign unused_branch = ^iENTRY_EX_BRANCH;
`endif

    always_comb begin
        head_p1 = head_q + PTR_W'(1);

        n_reg = 2'd0;
        if (!iLOCK) begin
            n_reg = {1'b0, iREGIST_0_VALID} + {1'b0, iREGIST_1_VALID};
        end

        // Restart squashes retirement in the same cycle it is raised.
        c0 = !iRESTART_VALID && iENTRY_EX_END[head_q];
`ifdef COMMIT_CTRL_DUAL_COMMIT_EN
        // A branch retires alone; the partner must be allocated and finished.
        c1 = c0 && !iENTRY_EX_BRANCH[head_q] && iENTRY_EX_END[head_p1]
                && (count_q >= CNT_W'(2));
`else
        c1 = 1'b0;
`endif
        n_com = {1'b0, c0} + {1'b0, c1};

        commit_vec          = '0;
        commit_vec[head_q]  = c0;
        commit_vec[head_p1] = c1;

        if (iRESTART_VALID) begin
            // Allocation in the restart cycle is discarded together with the ring.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(n_com);
            tail_d  = tail_q + PTR_W'(n_reg);
            count_d = count_q + CNT_W'(n_reg) - CNT_W'(n_com);
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Ring consistency: the head entry must be live whenever anything is outstanding,
    // and slot 1 may never allocate without slot 0.
    always_ff @(posedge iCLOCK) begin
        if (!iRESET_SYNC) begin
            assert (count_q == '0 || iENTRY_VALID[head_q]);
            assert (iLOCK || !iREGIST_1_VALID || iREGIST_0_VALID);
        end
    end

    assign oREGIST_POINTER = tail_q;
    // Two slots are allocated per cycle at most, so "full" means fewer than two free.
    assign oFULL           = count_q > CNT_W'(ENTRY_N - 2);
    assign oEMPTY          = (count_q == '0);
    assign oCOMMIT_VALID   = commit_vec;
    assign oCOMMIT_0_VALID = c0;
    assign oCOMMIT_0_TAG   = c0 ? head_q : '0;
    assign oCOMMIT_1_VALID = c1;
    assign oCOMMIT_1_TAG   = c1 ? head_p1 : '0;

endmodule

// File: tb/tb_commit_pointer_ctrl.sv
// Bench for commit_pointer_ctrl: directed ring scenarios followed by random traffic,
// every output compared each cycle against a queue-based model of the in-flight entries.
// The model holds the ordered list of allocated tags plus per-entry status bits.

module tb_commit_pointer_ctrl;

    localparam int N     = 64;
    localparam int PTR_W = 6;
`ifdef COMMIT_CTRL_DUAL_COMMIT_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             lock_i, restart_i, reg0_i, reg1_i;
    logic [N-1:0]     ev, ex, br;
    logic [PTR_W-1:0] regist_ptr;
    logic             full_o, empty_o;
    logic [N-1:0]     commit_vec;
    logic             c0_vld, c1_vld;
    logic [PTR_W-1:0] c0_tag, c1_tag;

    int n_vec = 0;
    int n_err = 0;

    // Model state: ordered in-flight tags and allocation pointer.
    int q[$];
    int tail_m;

    always #5 clk = ~clk;

    commit_pointer_ctrl #(.PTR_W(PTR_W), .ENTRY_N(N)) dut (
        .iCLOCK           (clk),
        .iRESET_SYNC      (rst),
        .iLOCK            (lock_i),
        .iRESTART_VALID   (restart_i),
        .iREGIST_0_VALID  (reg0_i),
        .iREGIST_1_VALID  (reg1_i),
        .iENTRY_VALID     (ev),
        .iENTRY_EX_END    (ex),
        .iENTRY_EX_BRANCH (br),
        .oREGIST_POINTER  (regist_ptr),
        .oFULL            (full_o),
        .oEMPTY           (empty_o),
        .oCOMMIT_VALID    (commit_vec),
        .oCOMMIT_0_VALID  (c0_vld),
        .oCOMMIT_0_TAG    (c0_tag),
        .oCOMMIT_1_VALID  (c1_vld),
        .oCOMMIT_1_TAG    (c1_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        q.delete();
        tail_m = 0;
        ev = '0;
        ex = '0;
        br = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; lock_i = 1'b0; restart_i = 1'b0; reg0_i = 1'b0; reg1_i = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: apply inputs, compare all outputs mid-cycle, advance the model at the edge.
    task automatic cyc(input bit lock, input bit r0, input bit r1, input bit rs);
        int nreg;
        int ncom;
        bit c0;
        bit c1;
        logic [N-1:0] vec;
        int t0;
        int t1;
        lock_i = lock; reg0_i = r0; reg1_i = r1; restart_i = rs;
        nreg = lock ? 0 : int'(r0) + int'(r1);
        assert (!(q.size() > N - 2 && nreg != 0));
        c0 = !rs && q.size() > 0 && ex[q[0]];
        c1 = DUAL && c0 && !br[q[0]] && q.size() >= 2 && ex[q[1]];
        t0 = c0 ? q[0] : 0;
        t1 = c1 ? q[1] : 0;
        vec = '0;
        if (c0) vec[t0] = 1'b1;
        if (c1) vec[t1] = 1'b1;
        @(negedge clk);
        chk("regist_ptr", regist_ptr, tail_m);
        chk("full",       full_o, (N - q.size()) < 2);
        chk("empty",      empty_o, q.size() == 0);
        chk("commit_vec", commit_vec, vec);
        chk("c0_vld",     c0_vld, c0);
        chk("c0_tag",     c0_tag, t0);
        chk("c1_vld",     c1_vld, c1);
        chk("c1_tag",     c1_tag, t1);
        @(posedge clk);
        #1;
        if (rs) begin
            clear_model();
        end else begin
            ncom = int'(c0) + int'(c1);
            for (int k = 0; k < ncom; k++) begin
                int t;
                t = q.pop_front();
                ev[t] = 1'b0; ex[t] = 1'b0; br[t] = 1'b0;
            end
            for (int k = 0; k < nreg; k++) begin
                q.push_back(tail_m);
                ev[tail_m] = 1'b1; ex[tail_m] = 1'b0; br[tail_m] = 1'b0;
                tail_m = (tail_m + 1) % N;
            end
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() > 0 && budget < 200) begin
            foreach (q[k]) ex[q[k]] = 1'b1;
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            budget++;
        end
        chk("drain_done", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_dut();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_ptr",   regist_ptr, 0);
        chk("rst_empty", empty_o, 1);

        // Two double allocations.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_ptr",   regist_ptr, 4);
        chk("t1_empty", empty_o, 0);

        // Entries 0,1 done; then a branch at 2 must retire alone before 3.
        ex[0] = 1'b1; ex[1] = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        ex[2] = 1'b1; br[2] = 1'b1; ex[3] = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_empty", empty_o, q.size() == 0);
        drain();

        // Allocate and retire two in the same cycle at count 10.
        repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        ex[q[0]] = 1'b1; ex[q[1]] = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Restart with outstanding finished head; allocation that cycle is dropped.
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ex[q[0]] = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rs_ptr",   regist_ptr, 0);
        chk("rs_empty", empty_o, 1);

        // Fill boundary: 62 not full, 63 full, locked allocation ignored.
        repeat (31) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("fill62_full", full_o, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("fill63_full", full_o, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("lock_ptr", regist_ptr, 63);
        drain();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrap_ptr", regist_ptr, 1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bit lk;
            bit rs;
            int r;
            foreach (q[k]) begin
                if (!ex[q[k]] && $urandom_range(2) == 0) begin
                    ex[q[k]] = 1'b1;
                    br[q[k]] = ($urandom_range(3) == 0);
                end
            end
            lk = ($urandom_range(4) == 0);
            r  = $urandom_range(2);
            if (!lk && q.size() > N - 2) r = 0;
            rs = ($urandom_range(59) == 0);
            cyc(lk, r >= 1, r == 2, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
